load_store_unit: RTL and testbench

MEM-stage load/store formatter sitting directly upstream of dataMemory, which exposes a word-only interface: clk, we, a, wd, rd. It accepts byte, halfword and word loads and stores from the pipeline. Sub-word stores are performed as a read-modify-write sequence, and loads are sign- or zero-extended. The pipeline is stalled via busy until done is pulsed.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and word-memory signals of the load/store unit.
// The master modport is the pipeline/memory environment; slave is the unit itself.
interface load_store_unit_if;
  logic        req;
  logic        is_store;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic [31:0] load_data;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req, is_store, size, unsigned_ld, addr, store_data, mem_rd,
    input  busy, done, addr_err, load_data, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req, is_store, size, unsigned_ld, addr, store_data, mem_rd,
    output busy, done, addr_err, load_data, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store formatter in front of a word-only data memory: sub-word stores
// become read-modify-write, sub-word loads are sign/zero-extended.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic             clk_i,
  input logic             reset_i,
  load_store_unit_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        err_q;
  logic [31:0] word_q;
  logic [31:0] load_data_q;

  logic        accept;
  logic        req_err;
  logic [1:0]  byte_lane;
  logic        half_lane;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;
  logic [31:0] merge_wd;

  assign accept = (state_q == StIdle) && bus_io.req;

  always_comb begin
    req_err = 1'b0;
    unique case (bus_io.size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = bus_io.addr[0];
      2'b10:   req_err = (bus_io.addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.req) begin
          if (req_err)                                     state_d = StDone;
          else if (bus_io.is_store && bus_io.size == 2'b10) state_d = StWrite;
          else                                             state_d = StRead;
        end
      end
      StRead:  state_d = is_store_q ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Lane of the addressed byte/half inside the memory word, after endianness mapping.
  assign byte_lane = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign half_lane = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
  assign rd_byte   = bus_io.mem_rd[{byte_lane, 3'b000} +: 8];
  assign rd_half   = bus_io.mem_rd[{half_lane, 4'b0000} +: 16];

  always_comb begin
    ld_ext = bus_io.mem_rd;
    unique case (size_q)
      2'b00:   ld_ext = unsigned_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ld_ext = unsigned_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_ext = bus_io.mem_rd;
    endcase
  end

  always_comb begin
    merge_wd = word_q;
    unique case (size_q)
      2'b00:   merge_wd[{byte_lane, 3'b000} +: 8]   = sdata_q[7:0];
      2'b01:   merge_wd[{half_lane, 4'b0000} +: 16] = sdata_q[15:0];
      default: merge_wd = sdata_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      addr_q      <= 32'b0;
      sdata_q     <= 32'b0;
      err_q       <= 1'b0;
      word_q      <= 32'b0;
      load_data_q <= 32'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= bus_io.is_store;
        size_q     <= bus_io.size;
        unsigned_q <= bus_io.unsigned_ld;
        addr_q     <= bus_io.addr;
        sdata_q    <= bus_io.store_data;
        err_q      <= req_err;
      end
      if (state_q == StRead) begin
        word_q <= bus_io.mem_rd;
        // Loads go READ -> DONE, so load_data is valid alongside done.
        if (!is_store_q) load_data_q <= ld_ext;
      end
    end
  end

  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = (state_q == StDone);
  assign bus_io.addr_err  = (state_q == StDone) && err_q;
  assign bus_io.load_data = load_data_q;
  assign bus_io.mem_we    = (state_q == StWrite);
  assign bus_io.mem_a     = {addr_q[31:2], 2'b00};
  assign bus_io.mem_wd    = (state_q == StWrite) ? merge_wd : 32'b0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: little- and big-endian instances on word memories, checked
// against a byte-addressed shadow memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic        st = 1'b0;
  logic [1:0]  sz = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'b0;
  logic [31:0] sdata = 32'b0;
  int          sel = 0;

  load_store_unit_if if0 ();
  load_store_unit_if if1 ();

  load_store_unit #(.BIG_ENDIAN(1'b0)) dut_le (.clk_i(clk), .reset_i(rst), .bus_io(if0));
  load_store_unit #(.BIG_ENDIAN(1'b1)) dut_be (.clk_i(clk), .reset_i(rst), .bus_io(if1));

  assign if0.req = req && (sel == 0);
  assign if1.req = req && (sel == 1);
  assign if0.is_store = st;
  assign if1.is_store = st;
  assign if0.size = sz;
  assign if1.size = sz;
  assign if0.unsigned_ld = uns;
  assign if1.unsigned_ld = uns;
  assign if0.addr = addr;
  assign if1.addr = addr;
  assign if0.store_data = sdata;
  assign if1.store_data = sdata;

  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  assign if0.mem_rd = mem0[if0.mem_a[7:2]];
  assign if1.mem_rd = mem1[if1.mem_a[7:2]];

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) begin
        mem0[i] <= 32'b0;
        mem1[i] <= 32'b0;
      end
    end else begin
      if (if0.mem_we) mem0[if0.mem_a[7:2]] <= if0.mem_wd;
      if (if1.mem_we) mem1[if1.mem_a[7:2]] <= if1.mem_wd;
    end
  end

  logic        obs_busy, obs_done, obs_err, obs_we;
  logic [31:0] obs_ld, obs_a, obs_wd;
  assign obs_busy = (sel == 1) ? if1.busy      : if0.busy;
  assign obs_done = (sel == 1) ? if1.done      : if0.done;
  assign obs_err  = (sel == 1) ? if1.addr_err  : if0.addr_err;
  assign obs_we   = (sel == 1) ? if1.mem_we    : if0.mem_we;
  assign obs_ld   = (sel == 1) ? if1.load_data : if0.load_data;
  assign obs_a    = (sel == 1) ? if1.mem_a     : if0.mem_a;
  assign obs_wd   = (sel == 1) ? if1.mem_wd    : if0.mem_wd;

  // Reference model: byte-addressed memory per instance plus the last load result.
  logic [7:0]  shadow [2][256];
  logic [31:0] ld_model [2];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int s, input int wa);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = (s == 1) ? shadow[s][wa + 3 - i] : shadow[s][wa + i];
    return w;
  endfunction

  function automatic logic [31:0] mem_word(input int s, input int wa);
    return (s == 1) ? mem1[wa / 4] : mem0[wa / 4];
  endfunction

  function automatic logic [31:0] model_load(input int s, input int a, input int n, input bit u);
    logic [31:0] v = 32'b0;
    for (int i = 0; i < n; i++) begin
      if (s == 1) v = (v << 8) | {24'b0, shadow[s][a + i]};
      else        v = v | ({24'b0, shadow[s][a + i]} << (8 * i));
    end
    if (n == 1) return u ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    if (n == 2) return u ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_store(input int s, input int a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++)
      shadow[s][a + i] = (s == 1) ? d[8*(n - 1 - i) +: 8] : d[8*i +: 8];
  endtask

  task automatic do_op(input bit s_st, input logic [1:0] s_sz, input bit s_uns,
                       input logic [31:0] s_a, input logic [31:0] s_d,
                       output logic [31:0] ld_o, output logic [31:0] wd_o);
    int done_at = 0, done_cnt = 0, we_at = 0, we_cnt = 0, lat, n, wa, a;
    logic err_seen = 1'b0, wd_leak = 1'b0, busy1 = 1'b0, e;
    logic [31:0] a_seen = 32'b0, wd_seen = 32'b0, ld_seen = 32'b0;
    @(negedge clk);
    chk("idle_busy", obs_busy, 1'b0);
    st = s_st; sz = s_sz; uns = s_uns; addr = s_a; sdata = s_d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = obs_busy;
      if (obs_we) begin
        we_cnt++; we_at = c; a_seen = obs_a; wd_seen = obs_wd;
      end else if (obs_wd !== 32'b0) wd_leak = 1'b1;
      if (obs_done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = c; err_seen = obs_err; ld_seen = obs_ld;
        end
      end
    end
    a  = int'(s_a[7:0]);
    wa = a & 32'hFC;
    n  = 1 << s_sz;
    e  = (s_sz == 2'b11) || (s_sz == 2'b01 && s_a[0]) || (s_sz == 2'b10 && s_a[1:0] != 2'b00);
    lat = e ? 1 : ((s_st && s_sz != 2'b10) ? 3 : 2);
    chk("busy_first_cycle", busy1, 1'b1);
    chk("done_latency", done_at, lat);
    chk("done_count", done_cnt, 1);
    chk("addr_err", err_seen, e);
    chk("we_count", we_cnt, (s_st && !e) ? 1 : 0);
    chk("wd_zero_outside_write", wd_leak, 1'b0);
    if (!s_st && !e) ld_model[sel] = model_load(sel, a, n, s_uns);
    chk("load_data", ld_seen, ld_model[sel]);
    if (s_st && !e) begin
      model_store(sel, a, n, s_d);
      chk("we_cycle", we_at, lat - 1);
      chk("mem_a", a_seen, wa);
      chk("mem_wd", wd_seen, model_word(sel, wa));
    end
    chk("mem_word", mem_word(sel, wa), model_word(sel, wa));
    ld_o = ld_seen;
    wd_o = wd_seen;
  endtask

  initial begin
    logic [31:0] ld, wd, dv, ld1;
    int n1, n2, dcnt;
    logic busy_gap, busy_after, we_w, we_r, busy_r, done_seen;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) shadow[s][i] = 8'h00;
      ld_model[s] = 32'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", if0.busy, 1'b0);
    chk("rst_done", if0.done, 1'b0);
    chk("rst_err", if0.addr_err, 1'b0);
    chk("rst_we", if0.mem_we, 1'b0);
    chk("rst_load_data", if0.load_data, 32'b0);
    chk("rst_mem_a", if0.mem_a, 32'b0);
    chk("rst_mem_wd", if0.mem_wd, 32'b0);
    rst = 1'b0;
    init = 1'b0;

    // Word store then load back.
    sel = 0;
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, ld, wd);
    chk("sw_wd_literal", wd, 32'hDEADBEEF);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, ld, wd);
    chk("lw_literal", ld, 32'hDEADBEEF);

    // Sub-word loads, little then big endian.
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h8899AABB, ld, wd);
    do_op(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, ld, wd);
    chk("lb_23", ld, 32'hFFFFFF88);
    do_op(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, ld, wd);
    chk("lbu_23", ld, 32'h00000088);
    do_op(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, ld, wd);
    chk("lh_20", ld, 32'hFFFFAABB);
    do_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, ld, wd);
    chk("lhu_22", ld, 32'h00008899);
    sel = 1;
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h8899AABB, ld, wd);
    do_op(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, ld, wd);
    chk("be_lb_20", ld, 32'hFFFFFF88);

    // Read-modify-write stores.
    sel = 0;
    do_op(1'b1, 2'b00, 1'b0, 32'h21, 32'h12345677, ld, wd);
    chk("sb_21_wd", wd, 32'h889977BB);
    do_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, ld, wd);
    chk("sh_22_wd", wd, 32'hCAFE77BB);

    // Illegal requests leave memory and load_data untouched.
    do_op(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, ld, wd);
    do_op(1'b1, 2'b01, 1'b0, 32'h21, 32'h5555AAAA, ld, wd);
    do_op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, ld, wd);
    chk("err_load_data_kept", ld, 32'h00008899);

    // Reset during the WRITE cycle of a byte store.
    @(negedge clk);
    st = 1'b1; sz = 2'b00; uns = 1'b0; addr = 32'h21; sdata = 32'h000000AB; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rmw_write_we", obs_we, 1'b1);
    rst = 1'b1;
    #1;
    we_r = obs_we;
    busy_r = obs_busy;
    chk("reset_we_drop", we_r, 1'b0);
    chk("reset_busy_drop", busy_r, 1'b0);
    done_seen = 1'b0;
    @(negedge clk);
    if (obs_done) done_seen = 1'b1;
    rst = 1'b0;
    ld_model[0] = 32'b0;
    ld_model[1] = 32'b0;
    repeat (2) begin
      @(negedge clk);
      if (obs_done) done_seen = 1'b1;
    end
    chk("reset_no_done", done_seen, 1'b0);
    chk("reset_mem_kept", mem_word(0, 32'h20), 32'hCAFE77BB);
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, ld, wd);
    chk("lw_after_reset", ld, 32'hCAFE77BB);

    // Back-to-back with req held high.
    dv = $urandom;
    @(negedge clk);
    st = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h10; req = 1'b1;
    n1 = 0; n2 = 0; dcnt = 0; busy_gap = 1'b1; busy_after = 1'b0; ld1 = 32'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (n1 != 0 && c == n1 + 1) busy_gap = obs_busy;
      if (n1 != 0 && c == n1 + 2) busy_after = obs_busy;
      if (obs_done) begin
        dcnt++;
        if (n1 == 0) begin
          n1 = c; ld1 = obs_ld; st = 1'b1; addr = 32'h14; sdata = dv;
        end else if (n2 == 0) begin
          n2 = c; req = 1'b0;
        end
      end
    end
    req = 1'b0;
    ld_model[0] = model_load(0, 32'h10, 4, 1'b0);
    model_store(0, 32'h14, 4, dv);
    chk("b2b_first_done", n1, 2);
    chk("b2b_gap", n2 - n1, 3);
    chk("b2b_done_count", dcnt, 2);
    chk("b2b_idle_between", busy_gap, 1'b0);
    chk("b2b_busy_second", busy_after, 1'b1);
    chk("b2b_lw", ld1, 32'hDEADBEEF);
    chk("b2b_sw_mem", mem_word(0, 32'h14), model_word(0, 32'h14));

    // Random operations on both instances.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  r_sz;
      logic [31:0] r_a;
      sel  = int'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_a  = 32'($urandom_range(0, 255));
      if (r_sz != 2'b11 && $urandom_range(0, 3) != 0) r_a = r_a & ~((32'd1 << r_sz) - 32'd1);
      do_op(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)), r_a, $urandom, ld, wd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
